// File: rtl/pic_priority_resolver.sv
// 8259A-style interrupt request/in-service engine: IRR latching, fully nested
// priority resolution, two-pulse INTA acknowledge, EOI and priority rotation.
module pic_priority_resolver (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_ir,
  input  logic       i_ltim,
  input  logic [7:0] i_imr,
  input  logic       i_aeoi,
  input  logic       i_rot_aeoi,
  input  logic       i_inta_pulse,
  input  logic       i_eoi_ns,
  input  logic       i_eoi_sp,
  input  logic       i_eoi_rot,
  input  logic       i_set_prio,
  input  logic [2:0] i_cmd_level,
  output logic       o_int,
  output logic [7:0] o_irr,
  output logic [7:0] o_isr,
  output logic [2:0] o_vec_level,
  output logic       o_vec_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_ACK2 = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_irr;
  logic [7:0] r_isr;
  logic [7:0] r_ir_q;
  logic [2:0] r_low_prio;
  logic [2:0] r_sel;
  logic       r_spur;
  logic       r_int;
  logic       r_vec_valid;
  logic [2:0] r_vec_level;

  logic [3:0] w_cand;
  logic [3:0] w_cur;
  logic       w_pending;
  logic       w_ack1;
  logic       w_ack2;
  logic       w_int_allow;
  logic [7:0] w_ack_mask;
  logic [7:0] w_aeoi_clr;
  logic [7:0] w_eoi_clr;
  logic       w_eoi_rot_vld;
  logic [2:0] w_eoi_rot_lvl;
  logic [2:0] w_low_prio_nxt;
  logic [7:0] w_irr_nxt;
  logic [7:0] w_isr_nxt;

  // Rank 0 is the highest priority level, i.e. the one just after low_prio.
  function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] lp);
    return lvl - lp - 3'd1;
  endfunction

  // Returns {found, level} of the highest-priority set bit.
  function automatic logic [3:0] f_highest(input logic [7:0] vec, input logic [2:0] lp);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = lp + 3'd1 + k[2:0];
      if (vec[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_cand    = f_highest(r_irr & ~i_imr, r_low_prio);
  assign w_cur     = f_highest(r_isr, r_low_prio);
  assign w_pending = w_cand[3] &&
                     (!w_cur[3] || (f_rank(w_cand[2:0], r_low_prio) < f_rank(w_cur[2:0], r_low_prio)));

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; INTA seen in ACK2 is dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = i_inta_pulse ? ST_ACK1 : ST_IDLE;
      ST_ACK1: w_state_nxt = i_inta_pulse ? ST_ACK2 : ST_ACK1;
      ST_ACK2: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode: acknowledge strobes and INT enable.
  always_comb begin
    w_ack1      = 1'b0;
    w_ack2      = 1'b0;
    w_int_allow = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ack1      = i_inta_pulse;
        w_int_allow = !i_inta_pulse;
      end
      ST_ACK1: w_ack2 = i_inta_pulse;
      ST_ACK2: w_ack2 = 1'b0;
      default: w_ack2 = 1'b0;
    endcase
  end

  // EOI target comes from the pre-update ISR; rotation writers ranked SET_PRIO > EOI > AEOI.
  always_comb begin
    w_ack_mask    = (w_ack1 && w_pending) ? (8'd1 << w_cand[2:0]) : 8'd0;
    w_aeoi_clr    = (w_ack2 && i_aeoi && !r_spur) ? (8'd1 << r_sel) : 8'd0;
    w_eoi_clr     = 8'd0;
    w_eoi_rot_vld = 1'b0;
    w_eoi_rot_lvl = 3'd0;
    if (i_eoi_sp) begin
      w_eoi_clr     = 8'd1 << i_cmd_level;
      w_eoi_rot_vld = i_eoi_rot;
      w_eoi_rot_lvl = i_cmd_level;
    end else if (i_eoi_ns && w_cur[3]) begin
      w_eoi_clr     = 8'd1 << w_cur[2:0];
      w_eoi_rot_vld = i_eoi_rot;
      w_eoi_rot_lvl = w_cur[2:0];
    end else begin
      w_eoi_clr     = 8'd0;
    end

    if (i_set_prio) begin
      w_low_prio_nxt = i_cmd_level;
    end else if (w_eoi_rot_vld) begin
      w_low_prio_nxt = w_eoi_rot_lvl;
    end else if (w_ack2 && i_aeoi && i_rot_aeoi && !r_spur) begin
      w_low_prio_nxt = r_sel;
    end else begin
      w_low_prio_nxt = r_low_prio;
    end

    if (i_ltim) begin
      w_irr_nxt = i_ir & ~w_ack_mask;
    end else begin
      w_irr_nxt = (r_irr | (i_ir & ~r_ir_q)) & ~w_ack_mask;
    end
    w_isr_nxt = (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_ack_mask;
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_irr       <= 8'd0;
      r_isr       <= 8'd0;
      r_ir_q      <= 8'd0;
      r_low_prio  <= 3'd7;
      r_sel       <= 3'd0;
      r_spur      <= 1'b0;
      r_int       <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vec_level <= 3'd0;
    end else begin
      r_irr       <= w_irr_nxt;
      r_isr       <= w_isr_nxt;
      r_ir_q      <= i_ir;
      r_low_prio  <= w_low_prio_nxt;
      r_int       <= w_pending && w_int_allow;
      r_vec_valid <= w_ack2;
      if (w_ack1) begin
        r_sel  <= w_pending ? w_cand[2:0] : 3'd7;
        r_spur <= !w_pending;
      end else begin
        r_sel  <= r_sel;
        r_spur <= r_spur;
      end
      if (w_ack2) begin
        r_vec_level <= r_sel;
      end else begin
        r_vec_level <= r_vec_level;
      end
    end
  end

  assign o_int       = r_int;
  assign o_irr       = r_irr;
  assign o_isr       = r_isr;
  assign o_vec_level = r_vec_level;
  assign o_vec_valid = r_vec_valid;

endmodule

// File: doc/pic_priority_resolver.md
# pic_priority_resolver

Interrupt request/in-service engine for the 8259A-compatible PIC. It latches IR lines into the IRR, gates them with the IMR mask, and resolves the highest-priority request against the in-service register. It drives INT toward the CPU, runs the two-pulse INTA acknowledge sequence, and handles EOI and priority-rotation commands from control logic. It sits directly downstream of the IMR block and upstream of the vector/data-bus driver.

## Interface
- No parameters; the width is fixed at 8 IR levels.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `IR` in 8: interrupt request lines, already synchronized to `clk`.
- `LTIM` in 1: 1 selects level-triggered IRR, 0 selects edge-triggered IRR.
- `IMR` in 8: mask from the IMR block; 1 = masked.
- `AEOI` in 1: automatic EOI mode.
- `ROT_AEOI` in 1: rotate priority on automatic EOI.
- `INTA_pulse` in 1: one-cycle strobe per INTA falling edge, from control logic.
- `EOI_ns` in 1: one-cycle strobe for a non-specific EOI.
- `EOI_sp` in 1: one-cycle strobe for a specific EOI of level `cmd_level`.
- `EOI_rot` in 1: qualifies `EOI_ns`/`EOI_sp` as a rotating EOI.
- `SET_PRIO` in 1: one-cycle strobe that sets the lowest-priority level to `cmd_level`.
- `cmd_level` in 3: level operand for `EOI_sp` and `SET_PRIO`.
- `INT` out 1: interrupt request to the CPU; registered.
- `IRR_out` out 8: current IRR.
- `ISR_out` out 8: current ISR.
- `vec_level` out 3: level being acknowledged; valid with `vec_valid`.
- `vec_valid` out 1: one-cycle strobe after the second INTA.

## Operation
- **Priority pointer `low_prio` (3 b):**
  - Reset value is 7, so IR0 is highest priority.
  - Priority order runs `low_prio+1` (highest) up to `low_prio` (lowest), modulo 8.
- **IRR:**
  - Edge mode: bit i sets when `IR[i]` is 1 and `IR_q[i]` is 0, where `IR_q` is the previous-cycle sample. The bit holds until it is acknowledged.
  - Level mode: bit i follows `IR[i]` each cycle.
  - In both modes, the bit being acknowledged is cleared on the first INTA. In level mode it re-latches if `IR` is still high.
  - Masked bits still latch.
- **Resolution:**
  - `cand` = the highest-priority bit of `IRR & ~IMR`.
  - `cur` = the highest-priority bit of ISR.
  - A request is pending when `cand` exists and either ISR is empty or `cand` has strictly higher priority than `cur`. This is fully nested mode; special mask mode is not supported.
- **INT:** registered copy of "request pending". It is forced to 0 from the first INTA until the FSM returns to IDLE.
- **FSM states:** IDLE, ACK1, ACK2.
  - IDLE → ACK1 on `INTA_pulse`:
    - Freeze `sel = cand` if a request is pending; otherwise `sel = 7` (spurious).
    - If not spurious, set `ISR[sel]` and clear `IRR[sel]`.
  - ACK1 → ACK2 on `INTA_pulse`:
    - Drive `vec_level = sel` and pulse `vec_valid` for one cycle.
    - If `AEOI` is set and the request was not spurious, clear `ISR[sel]`. If `ROT_AEOI` is also set, `low_prio = sel`.
  - ACK2 → IDLE unconditionally on the next cycle.
  - `INTA_pulse` received in ACK2 is ignored.
- **Non-specific EOI:**
  - Clears the highest-priority ISR bit. A no-op if ISR is empty.
  - With `EOI_rot`, `low_prio` becomes that cleared level.
- **Specific EOI:**
  - Clears `ISR[cmd_level]`.
  - With `EOI_rot`, `low_prio = cmd_level`, even if that bit was already clear.
- **SET_PRIO:** `low_prio = cmd_level`; no ISR change.
- **Simultaneous events:**
  - ISR update: `ISR_next = (ISR & ~eoi_clr) | ack_set`.
  - The EOI target is computed from the pre-update ISR.
  - If EOI and `SET_PRIO`/AEOI-rotate write `low_prio` in the same cycle, the priority order is: `SET_PRIO`, then EOI rotate, then AEOI rotate.

## Timing
- **Reset values:** IRR, ISR and `IR_q` are 0; `low_prio` is 7; FSM is IDLE; `INT`, `vec_valid` and `vec_level` are 0.
- **Reset mid-sequence:** an active reset mid-sequence aborts it and returns all state to the reset values on the next edge.
- **Request latency (edge mode):** `IR` rises, IRR is set at edge N+1, and `INT` is high at edge N+2.
- **Acknowledge timing:**
  - With INTA1 at cycle A, `INT` is 0 and ISR is set at edge A+1.
  - With INTA2 at cycle B, `vec_valid` is high for the cycle after edge B+1.
  - `INT` may re-assert one cycle after IDLE is re-entered.
- **Command timing:** EOI and `SET_PRIO` take effect at the next edge, and `INT` reflects the change one edge later.

## Test plan
- **Edge-mode acknowledge:**
  - Stimulus: reset, `LTIM=0`, `IMR=0`, pulse `IR[3]`.
  - Required: `INT=1` two cycles later.
  - Then two INTA pulses: `ISR=8'h08`, `IRR=0`, `vec_level=3` with `vec_valid`.
  - Then non-specific EOI: `ISR=0`.
- **Nesting and masking:**
  - Stimulus: `ISR[3]` in service, raise `IR[5]`.
  - Required: `INT` stays 0.
  - Raise `IR[1]`: `INT=1`, and the acknowledge gives level 1 with `ISR=8'h0A`.
  - With `IMR=8'h02`, `IR[1]` latches into IRR but `INT` stays 0.
- **Spurious acknowledge:**
  - Stimulus: INTA pulses with IRR empty.
  - Required: `vec_level=7`, ISR unchanged at 0.
- **AEOI with rotation:**
  - Stimulus: `AEOI=1`, `ROT_AEOI=1`, acknowledge `IR[2]`.
  - Required: ISR returns to 0 after INTA2.
  - Then `IR[2]` and `IR[3]` simultaneously: `IR[3]` wins, since `low_prio` is now 2.
- **Specific rotate and SET_PRIO:**
  - Stimulus: `SET_PRIO` with level 4, then `IR[4]` and `IR[5]` together.
  - Required: level 5 acknowledged first.
  - Then specific EOI with `EOI_rot` and level 5: `ISR[5]` cleared, `low_prio=5`.
- **Level mode and reset:**
  - Stimulus: `LTIM=1`, hold `IR[0]` high through the acknowledge.
  - Required: IRR bit 0 re-latches the cycle after INTA1.
  - Assert `rst_n=0` during ACK1: all outputs are 0 next edge and the FSM is IDLE.
